// File: rtl/servo_pwm_pkg.sv
// Shared constants and width arithmetic for the multi-channel servo PWM block.
// Build option SERVO_PWM_SLEW_EN limits how far an active width may move per frame.
package servo_pwm_pkg;

   localparam int DEF_PERIOD_CYC = 1_000_000;
   localparam int DEF_PULSE_MIN  = 25_000;
   localparam int DEF_PULSE_MAX  = 125_000;
   localparam int DEF_STEP       = 5_000;
   localparam int DEF_SLEW_STEP  = 2_500;

   // 33 bits covers CNT_W+1 for any CNT_W up to 32, so no sum or difference can wrap.
   localparam int WIDE_W = 33;
   typedef logic [WIDE_W-1:0] wide_t;

   function automatic wide_t clamp(input wide_t w, input wide_t lo, input wide_t hi);
      if (w < lo) return lo;
      if (w > hi) return hi;
      return w;
   endfunction

   function automatic wide_t sat_add(input wide_t cur, input wide_t step, input wide_t hi);
      wide_t sum;
      sum = cur + step;
      return (sum > hi) ? hi : sum;
   endfunction

   function automatic wide_t sat_sub(input wide_t cur, input wide_t step, input wide_t lo);
      return (cur < lo + step) ? lo : cur - step;
   endfunction

   // Step cur toward tgt by at most lim, landing exactly on tgt when close enough.
   function automatic wide_t move_toward(input wide_t cur, input wide_t tgt, input wide_t lim);
      if (tgt >= cur) return (tgt - cur <= lim) ? tgt : cur + lim;
      return (cur - tgt <= lim) ? tgt : cur - lim;
   endfunction

endpackage

// File: rtl/servo_pwm_if.sv
// Direct target-write port of servo_pwm_multi.
// A write transfers in every cycle where load_valid && load_ready; the payload is only
// meaningful while load_valid is high, and the slave never stalls outside reset.
interface servo_pwm_if #(
   parameter int LCH_W = 2,
   parameter int CNT_W = 20
);
   logic             load_valid;
   logic             load_ready;
   logic [LCH_W-1:0] load_ch;
   logic [CNT_W-1:0] load_width;

   modport master (output load_valid, output load_ch, output load_width, input load_ready);
   modport slave  (input load_valid, input load_ch, input load_width, output load_ready);
endinterface

// File: rtl/servo_pwm_channel.sv
// One servo channel: button edge detect, target/active width and the PWM comparator.
// SERVO_PWM_SLEW_EN: active width moves at most SLEW_STEP per frame instead of jumping.
module servo_pwm_channel
   import servo_pwm_pkg::*;
#(
   parameter int CNT_W     = 20,
   parameter int PULSE_MIN = DEF_PULSE_MIN,
   parameter int PULSE_MAX = DEF_PULSE_MAX,
   parameter int STEP      = DEF_STEP,
   parameter int SLEW_STEP = DEF_SLEW_STEP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             frame_start,
   input  logic [CNT_W-1:0] cnt,
   input  logic             inc,
   input  logic             dec,
   input  logic             load_hit,
   input  logic [CNT_W-1:0] load_width,
   output logic             pwm_out
);

   localparam wide_t MIN_W  = wide_t'(PULSE_MIN);
   localparam wide_t MAX_W  = wide_t'(PULSE_MAX);
   localparam wide_t STEP_W = wide_t'(STEP);
`ifdef SERVO_PWM_SLEW_EN
   localparam wide_t LIM_W  = wide_t'(SLEW_STEP);
`else
   // A limit spanning the whole legal range makes every frame land directly on target.
   localparam wide_t LIM_W  = wide_t'((SLEW_STEP > PULSE_MAX - PULSE_MIN) ? SLEW_STEP
                                                                          : PULSE_MAX - PULSE_MIN);
`endif

   logic             inc_q;
   logic             dec_q;
   logic             inc_rise;
   logic             dec_rise;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] active;

   assign inc_rise = inc && !inc_q;
   assign dec_rise = dec && !dec_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         target  <= CNT_W'(PULSE_MIN);
         active  <= CNT_W'(PULSE_MIN);
         pwm_out <= 1'b0;
      end else begin
         inc_q <= inc;
         dec_q <= dec;
         // A load wins over buttons; coincident inc/dec edges cancel.
         if (load_hit)
            target <= CNT_W'(clamp(wide_t'(load_width), MIN_W, MAX_W));
         else if (inc_rise && !dec_rise)
            target <= CNT_W'(sat_add(wide_t'(target), STEP_W, MAX_W));
         else if (dec_rise && !inc_rise)
            target <= CNT_W'(sat_sub(wide_t'(target), STEP_W, MIN_W));
         if (frame_start)
            active <= CNT_W'(move_toward(wide_t'(active), wide_t'(target), LIM_W));
         pwm_out <= enable && (cnt < active);
      end
   end

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator: shared frame counter, load decode, NUM_CH channels.
// SERVO_PWM_SLEW_EN: rate-limits each channel's active width change per frame.
module servo_pwm_multi
   import servo_pwm_pkg::*;
#(
   parameter int NUM_CH     = 3,
   parameter int PERIOD_CYC = DEF_PERIOD_CYC,
   parameter int PULSE_MIN  = DEF_PULSE_MIN,
   parameter int PULSE_MAX  = DEF_PULSE_MAX,
   parameter int STEP       = DEF_STEP,
   parameter int SLEW_STEP  = DEF_SLEW_STEP,
   parameter int CNT_W      = $clog2(PERIOD_CYC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [NUM_CH-1:0] inc,
   input  logic [NUM_CH-1:0] dec,
   servo_pwm_if.slave        load_bus,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              frame_start
);

   localparam int LCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [CNT_W-1:0]  cnt;
   logic              load_fire;
   logic [NUM_CH-1:0] load_hit;

   always_ff @(posedge clk) begin
      if (rst || !enable)
         cnt <= '0;
      else if (cnt == CNT_W'(PERIOD_CYC - 1))
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   // The counter parks at 0 while disabled, so enable rising starts a frame at once.
   assign frame_start         = enable && !rst && (cnt == '0);
   assign load_bus.load_ready = !rst;
   assign load_fire           = load_bus.load_valid && load_bus.load_ready;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Out-of-range channel indices match no channel and are silently dropped.
      assign load_hit[i] = load_fire && (load_bus.load_ch == LCH_W'(i));

      servo_pwm_channel #(
         .CNT_W     (CNT_W),
         .PULSE_MIN (PULSE_MIN),
         .PULSE_MAX (PULSE_MAX),
         .STEP      (STEP),
         .SLEW_STEP (SLEW_STEP)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .enable      (enable),
         .frame_start (frame_start),
         .cnt         (cnt),
         .inc         (inc[i]),
         .dec         (dec[i]),
         .load_hit    (load_hit[i]),
         .load_width  (load_bus.load_width),
         .pwm_out     (pwm_out[i])
      );
   end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: per-cycle behavioural model plus measured pulse widths.
// Expected widths follow SERVO_PWM_SLEW_EN when that macro is defined.
module tb_servo_pwm_multi;

   localparam int NCH    = 3;
   localparam int PERIOD = 1000;
   localparam int PMIN   = 50;
   localparam int PMAX   = 250;
   localparam int STEPV  = 10;
   localparam int SLEW   = 20;
   localparam int CW     = 10;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           enable = 1'b0;
   logic [NCH-1:0] inc = '0;
   logic [NCH-1:0] dec = '0;
   logic [NCH-1:0] pwm_out;
   logic           frame_start;

   servo_pwm_if #(.LCH_W(2), .CNT_W(CW)) lb ();

   servo_pwm_multi #(
      .NUM_CH(NCH), .PERIOD_CYC(PERIOD), .PULSE_MIN(PMIN), .PULSE_MAX(PMAX),
      .STEP(STEPV), .SLEW_STEP(SLEW), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .inc(inc), .dec(dec),
      .load_bus(lb), .pwm_out(pwm_out), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int             m_cnt;
   int             m_tgt [NCH];
   int             m_act [NCH];
   logic [NCH-1:0] m_pwm;
   logic [NCH-1:0] m_pinc;
   logic [NCH-1:0] m_pdec;
   bit             m_live = 0;
   bit             m_fs;

   function automatic int move_to(input int a, input int t);
`ifdef SERVO_PWM_SLEW_EN
      if (t > a) return (t - a <= SLEW) ? t : a + SLEW;
      return (a - t <= SLEW) ? t : a - SLEW;
`else
      return a * 0 + t;
`endif
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_cnt  = 0;
         m_pwm  = '0;
         m_pinc = '0;
         m_pdec = '0;
         for (int i = 0; i < NCH; i++) begin
            m_tgt[i] = PMIN;
            m_act[i] = PMIN;
         end
         m_live = 1;
      end else begin
         m_fs = enable && (m_cnt == 0);
         for (int i = 0; i < NCH; i++) begin
            m_pwm[i] = enable && (m_cnt < m_act[i]);
            if (m_fs) m_act[i] = move_to(m_act[i], m_tgt[i]);
            if (lb.load_valid && (int'(lb.load_ch) == i)) begin
               if (int'(lb.load_width) < PMIN)      m_tgt[i] = PMIN;
               else if (int'(lb.load_width) > PMAX) m_tgt[i] = PMAX;
               else                                 m_tgt[i] = int'(lb.load_width);
            end else if (inc[i] && !m_pinc[i] && !(dec[i] && !m_pdec[i])) begin
               m_tgt[i] = (m_tgt[i] + STEPV > PMAX) ? PMAX : m_tgt[i] + STEPV;
            end else if (dec[i] && !m_pdec[i] && !(inc[i] && !m_pinc[i])) begin
               m_tgt[i] = (m_tgt[i] - STEPV < PMIN) ? PMIN : m_tgt[i] - STEPV;
            end
         end
         m_pinc = inc;
         m_pdec = dec;
         m_cnt  = enable ? (m_cnt + 1) % PERIOD : 0;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("pwm_cycle", 32'(pwm_out), 32'(m_pwm));
         check("fs_cycle", 32'(frame_start), 32'(enable && !rst && (m_cnt == 0)));
         check("ready_cycle", 32'(lb.load_ready), 32'(!rst));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input int ch, input int w);
      lb.load_valid = 1'b1;
      lb.load_ch    = 2'(ch);
      lb.load_width = 10'(w);
      step(1);
      lb.load_valid = 1'b0;
   endtask

   task automatic pulse_inc(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         inc[ch] = 1'b1; step(2);
         inc[ch] = 1'b0; step(2);
      end
   endtask

   task automatic pulse_dec(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         dec[ch] = 1'b1; step(2);
         dec[ch] = 1'b0; step(2);
      end
   endtask

   task automatic wait_fs(output bit ok);
      ok = 0;
      for (int k = 0; k < 2100; k++) begin
         @(negedge clk);
         if (frame_start === 1'b1) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL fs_timeout: no frame_start within 2100 cycles at %0t", $time);
      end
   endtask

   // Counts high samples per channel over one frame, then the distance to the next frame_start.
   task automatic measure(output int w0, output int w1, output int w2, output int per);
      bit ok;
      w0 = 0; w1 = 0; w2 = 0; per = 0;
      wait_fs(ok);
      for (int k = 0; k < PERIOD; k++) begin
         if (k > 0) @(negedge clk);
         w0 += int'(pwm_out[0]);
         w1 += int'(pwm_out[1]);
         w2 += int'(pwm_out[2]);
      end
      per = PERIOD - 1;
      for (int k = 0; k < 2100; k++) begin
         @(negedge clk);
         per++;
         if (frame_start === 1'b1) break;
      end
   endtask

   // ---------------- directed sequence ----------------
   int w0, w1, w2, per;
   bit ok;

   initial begin
      lb.load_valid = 1'b0;
      lb.load_ch    = '0;
      lb.load_width = '0;

      // reset state
      step(5);
      @(negedge clk);
      check("rst_pwm", 32'(pwm_out), 0);
      check("rst_fs", 32'(frame_start), 0);
      check("rst_ready", 32'(lb.load_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      enable = 1'b1;

      // idle: every channel at minimum width
      measure(w0, w1, w2, per);
      check("idle_w0", w0, 50);
      check("idle_w1", w1, 50);
      check("idle_w2", w2, 50);
      check("idle_period", per, 1000);

      // three inc[0] edges mid-frame take effect at the next frame
      step(300);
      pulse_inc(0, 3);
      measure(w0, w1, w2, per);
`ifdef SERVO_PWM_SLEW_EN
      check("inc3_first_w0", w0, 70);
`else
      check("inc3_first_w0", w0, 80);
`endif
      measure(w0, w1, w2, per);
      check("inc3_settled_w0", w0, 80);

      // over-range load clamps; simultaneous edges cancel; bad channel ignored
      step(100);
      load(1, 400);
      inc[1] = 1'b1; dec[1] = 1'b1; step(2);
      inc[1] = 1'b0; dec[1] = 1'b0; step(2);
      load(3, 100);
      measure(w0, w1, w2, per);
      check("load_w0", w0, 80);
`ifdef SERVO_PWM_SLEW_EN
      check("load_w1", w1, 70);
`else
      check("load_w1", w1, 250);
`endif
      check("load_w2", w2, 50);

      // decrement saturation at the floor, held level gives one step
      step(50);
      pulse_dec(2, 25);
      measure(w0, w1, w2, per);
      check("dec25_w2", w2, 50);
      inc[2] = 1'b1; step(5000);
      inc[2] = 1'b0; step(3);
      measure(w0, w1, w2, per);
      check("held_inc_w2", w2, 60);

      // disable mid-frame, then restart
      wait_fs(ok);
      step(100);
      enable = 1'b0;
      step(1);
      @(negedge clk);
      check("dis_pwm", 32'(pwm_out), 0);
      check("dis_fs", 32'(frame_start), 0);
      step(50);
      @(negedge clk);
      check("dis_pwm_later", 32'(pwm_out), 0);
      @(posedge clk); #1;
      enable = 1'b1;
      @(negedge clk);
      check("reen_fs", 32'(frame_start), 1);
      measure(w0, w1, w2, per);
      check("reen_period", per, 1000);

      // reset mid-frame with ch0 at 200
      load(0, 200);
      step(8000);
      measure(w0, w1, w2, per);
      check("pre_rst_w0", w0, 200);
      step(599);
      rst = 1'b1;
      step(3);
      @(negedge clk);
      check("midrst_pwm", 32'(pwm_out), 0);
      check("midrst_fs", 32'(frame_start), 0);
      check("midrst_ready", 32'(lb.load_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_fs", 32'(frame_start), 1);
      measure(w0, w1, w2, per);
      check("post_rst_w0", w0, 50);
      check("post_rst_w1", w1, 50);
      check("post_rst_w2", w2, 50);
      check("post_rst_period", per, 1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

endmodule
